// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer
// ----------------------------------------------------------------------------
// This module is a small instruction queue between the fetch stage and decode.
// Each fetch cycle it stores {InstrF, PCF, PCPlus4F} in a circular buffer.
// It presents the oldest stored entry to decode through a valid/stall
// handshake.
//
// ReadyF drives the PC register enable. Fetch therefore stalls only when the
// queue is full. FlushD discards every queued entry; it is driven on a taken
// branch or a JALR resolved in execute.
//
// Optional feature (compile-time macro FETCH_BUFFER_BYPASS_EN):
//   When the macro is defined and the queue is empty, a valid fetch goes
//   straight to the decode outputs in the same cycle. This happens only when
//   decode is not stalled and no flush is pending. A forwarded instruction is
//   consumed directly and never written into the buffer. When the macro is
//   undefined, every instruction spends at least one cycle in the buffer.
//
// Parameters:
//   DATA_WIDTH : width of the instruction, PC and PC+4 fields
//   DEPTH      : number of entries (power of two, >= 2)
//   NOP_INSTR  : instruction shown on InstrD while the queue is empty
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset (highest priority)
//   ValidF     in   fetch presents an instruction this cycle
//   InstrF     in   fetched instruction
//   PCF        in   PC of the fetched instruction
//   PCPlus4F   in   PCF + 4
//   ReadyF     out  queue can accept (PC register enable)
//   StallD     in   decode cannot accept this cycle
//   FlushD     in   discard all queued entries
//   ValidD     out  head entry valid
//   InstrD     out  head instruction, NOP_INSTR when empty
//   PCD        out  head PC, zero when empty
//   PCPlus4D   out  head PC+4, zero when empty
//   CountO     out  current occupancy (debug)
// ============================================================================
module fetch_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ValidF,
    input  logic [DATA_WIDTH-1:0]      InstrF,
    input  logic [DATA_WIDTH-1:0]      PCF,
    input  logic [DATA_WIDTH-1:0]      PCPlus4F,
    output logic                       ReadyF,
    input  logic                       StallD,
    input  logic                       FlushD,
    output logic                       ValidD,
    output logic [DATA_WIDTH-1:0]      InstrD,
    output logic [DATA_WIDTH-1:0]      PCD,
    output logic [DATA_WIDTH-1:0]      PCPlus4D,
    output logic [$clog2(DEPTH):0]     CountO
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]      ZERO_PTR  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      ONE_PTR   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    // ------------------------------------------------------------------------
    // State. Entry storage is never cleared. Only the count and the pointers
    // decide which entries are valid.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] instr_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem_q     [DEPTH];
    logic [DATA_WIDTH-1:0] pcplus4_mem_q[DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic ready_s;
    logic head_valid_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;

    // Handshake qualifiers, all derived from registered count plus inputs.
    always_comb begin
        // ReadyF depends only on the registered count. This keeps StallD
        // from reaching the PC enable through a combinational path.
        ready_s      = (count_q < FULL_CNT);
        head_valid_s = (count_q != ZERO_CNT);
`ifdef FETCH_BUFFER_BYPASS_EN
        // On an empty queue the fetch input goes straight to decode.
        bypass_s     = (~head_valid_s) & ValidF & ~StallD & ~FlushD;
`else
        bypass_s     = 1'b0;
`endif
        // A forwarded instruction is consumed directly, so it is not stored.
        push_s       = ValidF & ready_s & ~FlushD & ~bypass_s;
        // Only a stored entry can be popped. A bypassed one never sits in the
        // buffer.
        pop_s        = head_valid_s & ~StallD & ~FlushD;
    end

    // Next-state logic for the pointers and the occupancy count.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (FlushD) begin
            // Flush empties the queue by pulling the read pointer up to the
            // write pointer. Any same-cycle fetch is already blocked by push_s.
            rd_ptr_d = wr_ptr_q;
            count_d  = ZERO_CNT;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + ONE_PTR;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_PTR;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    // Control-state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= ZERO_PTR;
            wr_ptr_q <= ZERO_PTR;
            count_q  <= ZERO_CNT;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port. The data is left unreset because validity
    // comes from the count alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[wr_ptr_q]   <= InstrF;
            pc_mem_q[wr_ptr_q]      <= PCF;
            pcplus4_mem_q[wr_ptr_q] <= PCPlus4F;
        end
    end

    // Decode-side outputs: the stored head entry, then the bypass path, then
    // the idle NOP.
    always_comb begin
        ValidD   = 1'b0;
        InstrD   = NOP_INSTR;
        PCD      = ZERO_DATA;
        PCPlus4D = ZERO_DATA;
        if (head_valid_s) begin
            ValidD   = 1'b1;
            InstrD   = instr_mem_q[rd_ptr_q];
            PCD      = pc_mem_q[rd_ptr_q];
            PCPlus4D = pcplus4_mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            ValidD   = 1'b1;
            InstrD   = InstrF;
            PCD      = PCF;
            PCPlus4D = PCPlus4F;
        end else begin
            ValidD   = 1'b0;
            InstrD   = NOP_INSTR;
            PCD      = ZERO_DATA;
            PCPlus4D = ZERO_DATA;
        end
    end

    // Fetch-side ready and debug occupancy.
    always_comb begin
        ReadyF = ready_s;
        CountO = count_q;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// tb_fetch_buffer
// ----------------------------------------------------------------------------
// Directed bench for fetch_buffer, built around a scoreboard.
//
// The stimulus tasks keep a small occupancy model. When the model accepts an
// instruction, the tasks push its expected PC onto a queue. A monitor runs on
// the falling clock edge and checks occupancy, ReadyF, ValidD and the empty
// outputs against that model. Whenever decode consumes the head entry, the
// monitor pops the queue and compares the PC, instruction and PC+4.
//
// Define FETCH_BUFFER_BYPASS_EN to match a bypass-enabled build of the design.
// ============================================================================
module tb_fetch_buffer;

    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BASE  = 32'hBFC0_0000;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          ValidF;
    logic [DW-1:0] InstrF;
    logic [DW-1:0] PCF;
    logic [DW-1:0] PCPlus4F;
    logic          ReadyF;
    logic          StallD;
    logic          FlushD;
    logic          ValidD;
    logic [DW-1:0] InstrD;
    logic [DW-1:0] PCD;
    logic [DW-1:0] PCPlus4D;
    logic [2:0]    CountO;

    fetch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk      (clk),
        .reset    (reset),
        .ValidF   (ValidF),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F),
        .ReadyF   (ReadyF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .ValidD   (ValidD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .CountO   (CountO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          model_cnt = 0;
    bit          run = 1'b0;
    logic [31:0] sb_q[$];
    logic        byp_now;
    logic        acc;
    logic [31:0] pc;
    logic [31:0] exp_pc;

    // Build an instruction from its PC, so each entry carries a distinct word.
    function automatic logic [31:0] mk_instr(input logic [31:0] p);
        return p ^ 32'h1234_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, update the model and predict the expected outputs.
    task automatic cycle(input logic vf, input logic [31:0] p, input logic st,
                         input logic fl, output logic accepted);
        logic byp;
        logic psh;
        logic pp;
        ValidF   = vf;
        PCF      = p;
        InstrF   = mk_instr(p);
        PCPlus4F = p + 32'd4;
        StallD   = st;
        FlushD   = fl;
        byp = BYP && (model_cnt == 0) && vf && !st && !fl;
        psh = vf && (model_cnt < DEPTH) && !fl && !byp;
        pp  = (model_cnt != 0) && !st && !fl;
        accepted = psh || byp;
        if (accepted) sb_q.push_back(p);
        @(posedge clk);
        #1;
        if (fl) begin
            model_cnt = 0;
            sb_q.delete();
        end else begin
            model_cnt = model_cnt + (psh ? 1 : 0) - (pp ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        ValidF   = 1'b0;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        PCF      = 32'h0;
        InstrF   = 32'h0;
        PCPlus4F = 32'h0;
        repeat (n) @(posedge clk);
        #1;
        model_cnt = 0;
        sb_q.delete();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: checks the model state and consumed entries.
    always @(negedge clk) begin
        if (run && !reset) begin
            byp_now = BYP && (model_cnt == 0) && ValidF && !StallD && !FlushD;
            chk("count", {29'd0, CountO}, 32'(model_cnt));
            chk("readyf", {31'd0, ReadyF}, {31'd0, (model_cnt < DEPTH)});
            chk("validd", {31'd0, ValidD}, {31'd0, ((model_cnt != 0) || byp_now)});
            if ((model_cnt == 0) && !byp_now) begin
                chk("empty_instr", InstrD, NOP);
                chk("empty_pc", PCD, 32'h0);
                chk("empty_pcp4", PCPlus4D, 32'h0);
            end
            if (ValidD && !StallD && !FlushD) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop", PCD, 32'hFFFF_FFFF);
                end else begin
                    exp_pc = sb_q.pop_front();
                    chk("pcd", PCD, exp_pc);
                    chk("instrd", InstrD, mk_instr(exp_pc));
                    chk("pcplus4d", PCPlus4D, exp_pc + 32'd4);
                end
            end
        end
    end

    initial begin
        ValidF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCF = 32'h0; InstrF = 32'h0; PCPlus4F = 32'h0;
        reset = 1'b1;
        run = 1'b1;

        // Reset state
        do_reset(2);
        chk("rst_validd", {31'd0, ValidD}, 32'd0);
        chk("rst_instrd", InstrD, 32'h0000_0013);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_readyf", {31'd0, ReadyF}, 32'd1);
        chk("rst_count", {29'd0, CountO}, 32'd0);

        // Streaming
        pc = BASE;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, pc, 1'b0, 1'b0, acc);
            if (acc) pc = pc + 32'd4;
        end
        chk("stream_validd", {31'd0, ValidD}, 32'd1);
        chk("stream_count", {29'd0, CountO}, BYP ? 32'd0 : 32'd1);
        idle(2);

        // Fill: four entries accepted, the fifth refused
        do_reset(1);
        pc = BASE;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, pc, 1'b1, 1'b0, acc);
            if (acc) pc = pc + 32'd4;
        end
        chk("fill_count", {29'd0, CountO}, 32'd4);
        chk("fill_readyf", {31'd0, ReadyF}, 32'd0);
        chk("fill_pcd", PCD, 32'hBFC0_0000);
        chk("fill_next_pc", pc, 32'hBFC0_0010);

        // Drain with wrap: the PC stays frozen until an entry is accepted
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, pc, 1'b0, 1'b0, acc);
            if (acc) pc = pc + 32'd4;
        end
        idle(6);

        // Flush at count 3 with a same-cycle fetch
        pc = BASE;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, pc, 1'b1, 1'b0, acc);
            pc = pc + 32'd4;
        end
        chk("preflush_count", {29'd0, CountO}, 32'd3);
        cycle(1'b1, 32'hBFC0_0020, 1'b1, 1'b1, acc);
        chk("flush_count", {29'd0, CountO}, 32'd0);
        chk("flush_validd", {31'd0, ValidD}, 32'd0);
        chk("flush_readyf", {31'd0, ReadyF}, 32'd1);
        cycle(1'b1, 32'hBFC0_0040, 1'b0, 1'b0, acc);
        idle(3);

        // Reset mid-fill
        pc = BASE + 32'h100;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, pc, 1'b1, 1'b0, acc);
            pc = pc + 32'd4;
        end
        chk("premid_count", {29'd0, CountO}, 32'd2);
        do_reset(1);
        chk("midrst_count", {29'd0, CountO}, 32'd0);
        chk("midrst_validd", {31'd0, ValidD}, 32'd0);
        cycle(1'b1, BASE, 1'b0, 1'b0, acc);
        idle(3);

        // Mixed stall/valid pattern exercising simultaneous push and pop
        pc = BASE + 32'h200;
        for (int i = 0; i < 30; i++) begin
            cycle((i % 4) != 3, pc, ((i % 3) == 0) || ((i % 5) == 1), 1'b0, acc);
            if (acc) pc = pc + 32'd4;
        end
        idle(8);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction queue between the fetch stage (PC register plus instruction memory) and decode.
- Captures {InstrF, PCF, PCPlus4F} each fetch cycle and presents the oldest entry to decode as a valid/stall handshake.
- Drives ReadyF back to the PC register's enable, so fetch stalls only when the queue is full.
- Flushed on a taken branch or JALR resolved in execute.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and PC+4 fields
- DEPTH, 4, number of entries; power of 2, minimum 2
- NOP_INSTR, 32'h00000013, instruction driven on InstrD when the queue is empty (addi x0,x0,0)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous active-high reset
- ValidF  input  1  fetch presents an instruction this cycle
- InstrF  input  DATA_WIDTH  fetched instruction
- PCF  input  DATA_WIDTH  PC of fetched instruction
- PCPlus4F  input  DATA_WIDTH  PCF+4
- ReadyF  output  1  queue can accept; wired to the PC register's enable
- StallD  input  1  decode cannot accept this cycle
- FlushD  input  1  discard all queued entries (PCSrcE | JALR in execute)
- ValidD  output  1  head entry valid
- InstrD  output  DATA_WIDTH  head instruction, or NOP_INSTR when empty
- PCD  output  DATA_WIDTH  head PC, or 0 when empty
- PCPlus4D  output  DATA_WIDTH  head PC+4, or 0 when empty
- CountO  output  $clog2(DEPTH)+1  current occupancy, for debug

Behaviour:
- Storage: circular buffer of DEPTH entries. Read pointer and write pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is separate, range 0..DEPTH.
- Reset (synchronous, highest priority):
  - pointers=0, count=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ReadyF=1.
  - Reset asserted mid-operation discards all entries on that edge.
- ReadyF = (count < DEPTH) combinationally from registered count. Does not depend on same-cycle pop, so there is no combinational path StallD->ReadyF.
- push = ValidF & ReadyF & ~FlushD.
- pop = ValidD & ~StallD & ~FlushD.
- ValidD = (count != 0). Outputs are driven combinationally from entry[rd_ptr].
- Latency: an entry pushed at edge N is visible on ValidD/InstrD after edge N (one-cycle latency). Ordering is strict FIFO.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Legal at count=DEPTH? No: ReadyF=0, so no push. Pop still occurs.
  - At count=0: no pop, since ValidD=0.
- FlushD (priority over push/pop, below reset): on that edge count=0 and rd_ptr=wr_ptr. Same-cycle fetch input is discarded. ReadyF=1 next cycle.
- StallD with count=DEPTH: hold all state. ReadyF=0, so PC freezes.
- Entry contents are not cleared on pop or flush. Only count and pointers define validity.
- No arithmetic on the data path. Fields are stored as given.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN
- Defined:
  - When count=0, ValidF=1, ~StallD and ~FlushD, the input is forwarded combinationally to InstrD/PCD/PCPlus4D with ValidD=1. It is consumed the same cycle and not written.
  - This gives zero-latency fetch->decode on an empty queue.
  - ReadyF is unchanged.
- Not defined: one-cycle minimum latency as above.

Test Plan:
- Reset: assert reset 2 cycles -> ValidD=0, InstrD=32'h00000013, PCD=0, ReadyF=1, CountO=0.
- Streaming: ValidF=1 each cycle with PCF=0xBFC00000,0xBFC00004,..., StallD=0 -> ValidD=1 from cycle 1 onward. PCD follows one cycle behind in order. CountO steady at 1 (0 with bypass).
- Fill: StallD=1, push 4 instrs (PCF 0xBFC00000..0xBFC0000C) -> CountO=4, ReadyF=0. A 5th ValidF is not accepted. PCD stays 0xBFC00000.
- Drain with wrap: from full, release StallD while ValidF=1 -> PCD sequence 0xBFC00000,04,08,0C,10. Pointers wrap past DEPTH with no duplicate or loss.
- Flush: count=3 and FlushD=1 with ValidF=1 (PCF=0xBFC00020) -> next cycle CountO=0, ValidD=0, ReadyF=1. PCF 0xBFC00020 is never presented.
- Reset mid-fill: count=2, assert reset -> next cycle CountO=0, ValidD=0. Subsequent push of PCF=0xBFC00000 appears as the first PCD.
